// File: rtl/rvh_l1d_lst_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rvh_l1d_lst_wr_arb
// Purpose  : Single write port arbiter for the L1D line-state table (LST).
//            Three sources share one registered write port:
//              - a full-table invalidation walk (after reset or on flush_req),
//              - pipeline MESI writes,
//              - snoop MESI writes.
//            The walk has absolute priority. Snoop normally beats the pipe,
//            but after STARVE_MAX consecutive pipe losses the pipe wins once.
// Ports    : clk, rst                    clock, synchronous active-high reset
//            pipe_wr_valid/ready/set/way/dat   pipeline write request
//            snp_wr_valid/ready/set/way/dat    snoop write request
//            flush_req                   single-cycle invalidate-all request
//            flush_busy                  high while INIT or WALK
//            flush_done                  one-cycle pulse after the walk ends
//            lst_wr_en/set_idx/way_idx/dat     registered LST write port
// Revision : 1.0 - initial release
// ============================================================================
module rvh_l1d_lst_wr_arb #(
    parameter int SET_NUM    = 32,
    parameter int SET_IDX_W  = 5,
    parameter int WAY_NUM    = 4,
    parameter int WAY_IDX_W  = 2,
    parameter int MESI_W     = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 pipe_wr_valid,
    output logic                 pipe_wr_ready,
    input  logic [SET_IDX_W-1:0] pipe_wr_set,
    input  logic [WAY_IDX_W-1:0] pipe_wr_way,
    input  logic [MESI_W-1:0]    pipe_wr_dat,

    input  logic                 snp_wr_valid,
    output logic                 snp_wr_ready,
    input  logic [SET_IDX_W-1:0] snp_wr_set,
    input  logic [WAY_IDX_W-1:0] snp_wr_way,
    input  logic [MESI_W-1:0]    snp_wr_dat,

    input  logic                 flush_req,
    output logic                 flush_busy,
    output logic                 flush_done,

    output logic                 lst_wr_en,
    output logic [SET_IDX_W-1:0] lst_wr_set_idx,
    output logic [WAY_IDX_W-1:0] lst_wr_way_idx,
    output logic [MESI_W-1:0]    lst_wr_dat
);

    localparam int c_CNT_W    = SET_IDX_W + WAY_IDX_W;
    localparam int c_STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [c_CNT_W-1:0]    c_CNT_LAST   = c_CNT_W'(SET_NUM * WAY_NUM - 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_IDLE = 2'd1;
    localparam logic [1:0] c_ST_WALK = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_walk_cnt;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic                  r_walk_last_q;
    logic                  r_flush_done;
    logic                  r_wr_en;
    logic [SET_IDX_W-1:0]  r_wr_set;
    logic [WAY_IDX_W-1:0]  r_wr_way;
    logic [MESI_W-1:0]     r_wr_dat;

    logic w_walking;
    logic w_walk_last;
    logic w_arb_open;
    logic w_starved;
    logic w_pipe_gnt;
    logic w_snp_gnt;

    // Any non-IDLE encoding is treated as walking so an illegal state can
    // never let requests through while the table is in an unknown condition.
    assign w_walking   = (r_state != c_ST_IDLE);
    assign w_walk_last = w_walking && (r_walk_cnt == c_CNT_LAST);
    assign w_starved   = (r_starve_cnt == c_STARVE_MAX);

    // A flush seen in IDLE claims the cycle, so arbitration stays closed.
    assign w_arb_open  = (r_state == c_ST_IDLE) && !flush_req && !rst;

    // Readies depend only on the competitor's valid, never on the
    // requester's own valid, so at most one grant can occur per cycle.
    assign snp_wr_ready  = w_arb_open && !(pipe_wr_valid && w_starved);
    assign pipe_wr_ready = w_arb_open && (!snp_wr_valid || w_starved);

    assign w_pipe_gnt = pipe_wr_valid && pipe_wr_ready;
    assign w_snp_gnt  = snp_wr_valid  && snp_wr_ready;

    // ------------------------------------------------------------------------
    // State machine and walk counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_INIT;
            r_walk_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_INIT, c_ST_WALK: begin
                    if (w_walk_last) begin
                        r_state    <= c_ST_IDLE;
                        r_walk_cnt <= '0;
                    end else begin
                        r_walk_cnt <= r_walk_cnt + 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (flush_req) begin
                        r_state <= c_ST_WALK;
                    end
                end
                default: begin
                    r_state    <= c_ST_INIT;
                    r_walk_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pipe starvation counter: counts consecutive snoop wins while the pipe
    // is waiting; any pipe win or pipe withdrawal resets the streak.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_pipe_gnt || !pipe_wr_valid) begin
            r_starve_cnt <= '0;
        end else if (w_snp_gnt && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Completion pulse: the last walk entry is issued in cycle T, shows on
    // the write port in T+1, and flush_done follows in T+2.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_walk_last_q <= 1'b0;
            r_flush_done  <= 1'b0;
        end else begin
            r_walk_last_q <= w_walk_last;
            r_flush_done  <= r_walk_last_q;
        end
    end

    // ------------------------------------------------------------------------
    // Registered LST write port. Payload holds its last value when idle to
    // avoid needless toggling; only lst_wr_en qualifies it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en  <= 1'b0;
            r_wr_set <= '0;
            r_wr_way <= '0;
            r_wr_dat <= '0;
        end else begin
            r_wr_en <= w_walking || w_pipe_gnt || w_snp_gnt;
            if (w_walking) begin
                r_wr_set <= r_walk_cnt[c_CNT_W-1:WAY_IDX_W];
                r_wr_way <= r_walk_cnt[WAY_IDX_W-1:0];
                r_wr_dat <= '0;
            end else if (w_pipe_gnt) begin
                r_wr_set <= pipe_wr_set;
                r_wr_way <= pipe_wr_way;
                r_wr_dat <= pipe_wr_dat;
            end else if (w_snp_gnt) begin
                r_wr_set <= snp_wr_set;
                r_wr_way <= snp_wr_way;
                r_wr_dat <= snp_wr_dat;
            end
        end
    end

    assign flush_busy     = w_walking;
    assign flush_done     = r_flush_done;
    assign lst_wr_en      = r_wr_en;
    assign lst_wr_set_idx = r_wr_set;
    assign lst_wr_way_idx = r_wr_way;
    assign lst_wr_dat     = r_wr_dat;

endmodule
`default_nettype wire

// File: tb/tb_rvh_l1d_lst_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvh_l1d_lst_wr_arb
// Purpose  : Self-checking bench for rvh_l1d_lst_wr_arb. A behavioural model
//            predicts readies and the next-cycle write port contents; each
//            prediction is queued and compared one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvh_l1d_lst_wr_arb;

    localparam int SET_NUM    = 32;
    localparam int SET_IDX_W  = 5;
    localparam int WAY_NUM    = 4;
    localparam int WAY_IDX_W  = 2;
    localparam int MESI_W     = 2;
    localparam int STARVE_MAX = 3;
    localparam int c_TOTAL    = SET_NUM * WAY_NUM;

    localparam int c_M_INIT = 0;
    localparam int c_M_IDLE = 1;
    localparam int c_M_WALK = 2;

    logic                 clk;
    logic                 rst;
    logic                 pipe_wr_valid;
    logic                 pipe_wr_ready;
    logic [SET_IDX_W-1:0] pipe_wr_set;
    logic [WAY_IDX_W-1:0] pipe_wr_way;
    logic [MESI_W-1:0]    pipe_wr_dat;
    logic                 snp_wr_valid;
    logic                 snp_wr_ready;
    logic [SET_IDX_W-1:0] snp_wr_set;
    logic [WAY_IDX_W-1:0] snp_wr_way;
    logic [MESI_W-1:0]    snp_wr_dat;
    logic                 flush_req;
    logic                 flush_busy;
    logic                 flush_done;
    logic                 lst_wr_en;
    logic [SET_IDX_W-1:0] lst_wr_set_idx;
    logic [WAY_IDX_W-1:0] lst_wr_way_idx;
    logic [MESI_W-1:0]    lst_wr_dat;

    rvh_l1d_lst_wr_arb #(
        .SET_NUM   (SET_NUM),
        .SET_IDX_W (SET_IDX_W),
        .WAY_NUM   (WAY_NUM),
        .WAY_IDX_W (WAY_IDX_W),
        .MESI_W    (MESI_W),
        .STARVE_MAX(STARVE_MAX)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wr_valid (pipe_wr_valid),
        .pipe_wr_ready (pipe_wr_ready),
        .pipe_wr_set   (pipe_wr_set),
        .pipe_wr_way   (pipe_wr_way),
        .pipe_wr_dat   (pipe_wr_dat),
        .snp_wr_valid  (snp_wr_valid),
        .snp_wr_ready  (snp_wr_ready),
        .snp_wr_set    (snp_wr_set),
        .snp_wr_way    (snp_wr_way),
        .snp_wr_dat    (snp_wr_dat),
        .flush_req     (flush_req),
        .flush_busy    (flush_busy),
        .flush_done    (flush_done),
        .lst_wr_en     (lst_wr_en),
        .lst_wr_set_idx(lst_wr_set_idx),
        .lst_wr_way_idx(lst_wr_way_idx),
        .lst_wr_dat    (lst_wr_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                 en;
        logic [SET_IDX_W-1:0] set;
        logic [WAY_IDX_W-1:0] way;
        logic [MESI_W-1:0]    dat;
        logic                 done;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp;
    int n_mis;
    int n_walk_wr;
    int n_done;

    // Model state, valid for the upcoming cycle
    int m_state;
    int m_cnt;
    int m_starve;
    bit m_last_q;
    bit m_pg;
    bit m_sg;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: check this cycle's outputs at the falling edge, run
    // the model forward, queue the next-cycle prediction, then pass the
    // rising edge and return with 1 time unit of margin for new stimulus.
    task automatic cycle();
        exp_t e;
        exp_t n;
        bit   open_arb;
        bit   starved;
        bit   e_pr;
        bit   e_sr;
        bit   walking;
        bit   last_now;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("lst_wr_en", 32'(lst_wr_en), 32'(e.en));
            if (e.en) begin
                chk("lst_wr_payload", 32'({lst_wr_set_idx, lst_wr_way_idx, lst_wr_dat}),
                    32'({e.set, e.way, e.dat}));
            end
            chk("flush_done", 32'(flush_done), 32'(e.done));
        end

        open_arb = (m_state == c_M_IDLE) && !rst && !flush_req;
        starved  = (m_starve == STARVE_MAX);
        e_sr     = open_arb && !(pipe_wr_valid && starved);
        e_pr     = open_arb && (!snp_wr_valid || starved);
        chk("pipe_wr_ready", 32'(pipe_wr_ready), 32'(e_pr));
        chk("snp_wr_ready", 32'(snp_wr_ready), 32'(e_sr));
        if (!rst) chk("flush_busy", 32'(flush_busy), 32'(m_state != c_M_IDLE));

        m_pg = pipe_wr_valid && e_pr;
        m_sg = snp_wr_valid && e_sr;
        n    = '0;
        if (rst) begin
            m_state  = c_M_INIT;
            m_cnt    = 0;
            m_starve = 0;
            m_last_q = 1'b0;
            m_pg     = 1'b0;
            m_sg     = 1'b0;
        end else begin
            walking  = (m_state != c_M_IDLE);
            last_now = 1'b0;
            if (walking) begin
                n.en  = 1'b1;
                n.set = SET_IDX_W'(m_cnt / WAY_NUM);
                n.way = WAY_IDX_W'(m_cnt % WAY_NUM);
                n.dat = '0;
                n_walk_wr++;
                last_now = (m_cnt == c_TOTAL - 1);
                if (last_now) begin
                    m_state = c_M_IDLE;
                    m_cnt   = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                if (m_pg) begin
                    n.en = 1'b1; n.set = pipe_wr_set; n.way = pipe_wr_way; n.dat = pipe_wr_dat;
                end else if (m_sg) begin
                    n.en = 1'b1; n.set = snp_wr_set; n.way = snp_wr_way; n.dat = snp_wr_dat;
                end
                if (flush_req) m_state = c_M_WALK;
            end
            if (m_pg || !pipe_wr_valid) m_starve = 0;
            else if (m_sg && m_starve < STARVE_MAX) m_starve = m_starve + 1;
            n.done   = m_last_q;
            if (m_last_q) n_done++;
            m_last_q = last_now;
        end
        exp_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; n_walk_wr = 0; n_done = 0;
        m_state = c_M_INIT; m_cnt = 0; m_starve = 0; m_last_q = 1'b0;
        m_pg = 1'b0; m_sg = 1'b0;
        rst = 1'b1; flush_req = 1'b0;
        pipe_wr_valid = 1'b0; pipe_wr_set = '0; pipe_wr_way = '0; pipe_wr_dat = '0;
        snp_wr_valid  = 1'b0; snp_wr_set  = '0; snp_wr_way  = '0; snp_wr_dat  = '0;
        @(posedge clk);
        #1;

        // Reset, then the post-reset INIT walk with no traffic
        run(3);
        rst = 1'b0;
        run(c_TOTAL + 6);
        chk("init_walk_writes", 32'(n_walk_wr), 32'(c_TOTAL));
        chk("init_done_pulses", 32'(n_done), 32'(1));

        // Lone pipe write: set 5, way 2, dat 3
        pipe_wr_valid = 1'b1; pipe_wr_set = 5'd5; pipe_wr_way = 2'd2; pipe_wr_dat = 2'd3;
        cycle();
        pipe_wr_valid = 1'b0;
        run(2);

        // Lone snoop write
        snp_wr_valid = 1'b1; snp_wr_set = 5'd17; snp_wr_way = 2'd1; snp_wr_dat = 2'd2;
        cycle();
        snp_wr_valid = 1'b0;
        run(2);

        // Both held valid: snp,snp,snp,pipe repeating
        pipe_wr_valid = 1'b1; pipe_wr_set = 5'd7; pipe_wr_way = 2'd1; pipe_wr_dat = 2'd2;
        snp_wr_valid  = 1'b1; snp_wr_set  = 5'd9; snp_wr_way  = 2'd3; snp_wr_dat  = 2'd1;
        run(14);

        // Flush with both valids high; second flush mid-walk is ignored
        n_walk_wr = 0; n_done = 0;
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        run(50);
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        run(c_TOTAL);
        chk("flush_walk_writes", 32'(n_walk_wr), 32'(c_TOTAL));
        chk("flush_done_pulses", 32'(n_done), 32'(1));
        pipe_wr_valid = 1'b0; snp_wr_valid = 1'b0;
        run(3);

        // Random traffic honouring hold-until-ready, occasional flushes
        for (int i = 0; i < 400; i++) begin
            if (!pipe_wr_valid || m_pg) begin
                pipe_wr_valid = ($urandom_range(0, 3) != 0);
                pipe_wr_set   = SET_IDX_W'($urandom);
                pipe_wr_way   = WAY_IDX_W'($urandom);
                pipe_wr_dat   = MESI_W'($urandom);
            end
            if (!snp_wr_valid || m_sg) begin
                snp_wr_valid = ($urandom_range(0, 2) != 0);
                snp_wr_set   = SET_IDX_W'($urandom);
                snp_wr_way   = WAY_IDX_W'($urandom);
                snp_wr_dat   = MESI_W'($urandom);
            end
            flush_req = ($urandom_range(0, 99) == 0);
            cycle();
        end
        flush_req = 1'b0; pipe_wr_valid = 1'b0; snp_wr_valid = 1'b0;

        // Reset asserted at walk entry 40, then a complete fresh walk
        for (int i = 0; i < 2 * c_TOTAL && m_state != c_M_IDLE; i++) cycle();
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        for (int i = 0; i < 100 && !(m_state == c_M_WALK && m_cnt == 40); i++) cycle();
        chk("reach_walk_entry_40", 32'(m_cnt), 32'(40));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_walk_wr = 0; n_done = 0;
        run(c_TOTAL + 6);
        chk("rst_walk_writes", 32'(n_walk_wr), 32'(c_TOTAL));
        chk("rst_done_pulses", 32'(n_done), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvh_l1d_lst_wr_arb.md
RVH_L1D_LST_WR_ARB -- requirements
Module: rvh_l1d_lst_wr_arb

Interface
REQ-001 SHALL have parameter SET_NUM, default 32, number of LST sets.
REQ-002 SHALL have parameter SET_IDX_W, default 5, clog2(SET_NUM).
REQ-003 SHALL have parameter WAY_NUM, default 4, ways per set.
REQ-004 SHALL have parameter WAY_IDX_W, default 2, clog2(WAY_NUM).
REQ-005 SHALL have parameter MESI_W, default 2, MESI state width; INVALID encoding = 0.
REQ-006 SHALL have parameter STARVE_MAX, default 3, maximum consecutive pipe losses to snoop.
REQ-007 SHALL have one clock; reset is synchronous and active-high: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-008 SHALL have pipe_wr_valid  in  1, pipe_wr_ready  out  1, pipe_wr_set  in  SET_IDX_W, pipe_wr_way  in  WAY_IDX_W, pipe_wr_dat  in  MESI_W: pipeline MESI write request.
REQ-009 SHALL have snp_wr_valid  in  1, snp_wr_ready  out  1, snp_wr_set  in  SET_IDX_W, snp_wr_way  in  WAY_IDX_W, snp_wr_dat  in  MESI_W: snoop MESI write request.
REQ-010 SHALL have flush_req  in  1, single-cycle request to invalidate the whole LST.
REQ-011 SHALL have flush_busy  out  1, high while INIT or WALK.
REQ-012 SHALL have flush_done  out  1, one-cycle pulse at walk completion.
REQ-013 SHALL have lst_wr_en  out  1, lst_wr_set_idx  out  SET_IDX_W, lst_wr_way_idx  out  WAY_IDX_W, lst_wr_dat  out  MESI_W: single registered LST write port.

Function
REQ-014 SHALL implement FSM states INIT, IDLE, WALK; INIT and WALK are identical except for entry cause.
REQ-015 INIT/WALK SHALL write INVALID to one entry per cycle, set-major/way-minor order from (0,0) to (SET_NUM-1,WAY_NUM-1): SET_NUM*WAY_NUM consecutive lst_wr_en cycles (128 by default).
REQ-016 Walk counter SHALL be SET_IDX_W+WAY_IDX_W bits; the cycle issuing the last entry SHALL transition to IDLE; flush_done SHALL pulse in the cycle after the last walk write is presented on lst_wr_*.
REQ-017 IDLE + flush_req SHALL enter WALK next cycle; no request handshake that cycle (flush wins over pipe and snoop).
REQ-018 flush_req during INIT/WALK SHALL be ignored (the ongoing walk covers it); walk SHALL NOT restart.
REQ-019 pipe_wr_ready and snp_wr_ready SHALL be 0 in INIT and WALK, and in IDLE when flush_req=1.
REQ-020 In IDLE without flush_req: snp_wr_ready = ~(pipe_wr_valid & starve_cnt==STARVE_MAX); pipe_wr_ready = ~snp_wr_valid | (starve_cnt==STARVE_MAX); ready is independent of the requester's own valid.
REQ-021 At most one handshake per cycle; grant = valid & ready.
REQ-022 starve_cnt SHALL increment (saturating at STARVE_MAX) when pipe_wr_valid=1 and snoop is granted; clear on pipe grant or when pipe_wr_valid=0.
REQ-023 A granted request SHALL appear on lst_wr_* exactly one cycle after handshake (latency 1), set/way/dat unchanged; lst_wr_en=0 when no grant and not walking.
REQ-024 Simultaneous pipe and snoop to the same set/way SHALL be serialized by REQ-020; no merging.
REQ-025 Requesters SHALL hold valid and payload stable until ready; the block SHALL NOT check this.

Reset
REQ-026 rst=1 SHALL force: state INIT, walk counter 0, starve_cnt 0, lst_wr_en 0, lst_wr_set_idx/way_idx/dat 0, flush_done 0, both readies 0.
REQ-027 flush_busy SHALL be 1 in the first cycle after rst deassertion; reset mid-walk SHALL restart INIT from (0,0).
REQ-028 rst SHALL take priority over flush_req and all requests in the same cycle.

Verification
REQ-029 Release rst, no requests -> 128 lst_wr_en cycles with dat=0, indices (0,0),(0,1)..(31,3); flush_done pulse once; flush_busy falls; readies rise.
REQ-030 IDLE, pipe (set 5, way 2, dat 3) alone -> pipe_wr_ready=1; next cycle lst_wr_en=1, set 5, way 2, dat 3.
REQ-031 Pipe and snoop held valid continuously -> grants snp,snp,snp,pipe repeating (STARVE_MAX=3); starve_cnt never exceeds 3.
REQ-032 IDLE, flush_req with both valids high -> no handshake that cycle; WALK starts next cycle; second flush_req mid-walk -> exactly 128 writes, single flush_done.
REQ-033 rst asserted at walk entry 40 -> outputs zero next cycle; after release full 128-entry walk from (0,0).
